// File: rtl/spi_master_param.sv
// SPI master with compile-time word width, SCK divider and chip-select timing.
// Words are requested one at a time with start; cs_n stays low between words
// until a word flagged with last has been sent, then released after CS_HOLD.
module spi_master_param #(
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 5,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              last,
    input  logic              abort,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              cs_n,
    output logic              sck,
    output logic              mosi,
    input  logic              miso
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

    localparam int EDGES = 2 * DATA_W;

    logic [2:0]        state;
    logic [15:0]       cnt;
    logic [6:0]        edge_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] tx_next;
    logic [DATA_W-1:0] rx_next;
    logic              last_r;
    logic              cpol_r;
    logic              cpha_r;
    logic              lsb_r;
    logic              div_hit;
    logic              final_edge;
    logic              sample_now;
    logic              update_now;

    // Bit currently presented on the line for a given word and bit order.
    function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATA_W-1];
    endfunction

    // Edge decoding: even edge indices are leading edges, odd are trailing.
    always_comb begin
        div_hit    = (cnt == 16'(CLK_DIV - 1));
        final_edge = (edge_cnt == 7'(EDGES - 1));
        sample_now = (edge_cnt[0] == cpha_r);
        update_now = cpha_r ? (!edge_cnt[0] && (edge_cnt != 7'd0))
                            : (edge_cnt[0] && !final_edge);
        tx_next    = lsb_r ? (tx_sh >> 1) : (tx_sh << 1);
        rx_next    = lsb_r ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
    end

    // Transfer FSM with all outputs registered; abort overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            last_r   <= 1'b0;
            cpol_r   <= 1'b0;
            cpha_r   <= 1'b0;
            lsb_r    <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cs_n     <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state != IDLE)) begin
                state    <= IDLE;
                cnt      <= '0;
                edge_cnt <= '0;
                busy     <= 1'b0;
                cs_n     <= 1'b1;
                sck      <= cpol;
                mosi     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sck  <= cpol;
                        mosi <= 1'b0;
                        if (start) begin
                            state  <= SETUP;
                            cnt    <= '0;
                            tx_sh  <= tx_data;
                            last_r <= last;
                            cpol_r <= cpol;
                            cpha_r <= cpha;
                            lsb_r  <= lsb_first;
                            busy   <= 1'b1;
                            cs_n   <= 1'b0;
                        end
                    end
                    SETUP: begin
                        if (cnt == 16'(CS_SETUP - 1)) begin
                            state    <= SHIFT;
                            cnt      <= '0;
                            edge_cnt <= '0;
                            mosi     <= first_bit(tx_sh, lsb_r);
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    SHIFT: begin
                        if (div_hit) begin
                            cnt <= '0;
                            sck <= ~sck;
                            if (final_edge) begin
                                rx_data  <= sample_now ? rx_next : rx_sh;
                                done     <= 1'b1;
                                mosi     <= 1'b0;
                                edge_cnt <= '0;
                                state    <= last_r ? HOLD : WAIT;
                                busy     <= last_r;
                            end else begin
                                edge_cnt <= edge_cnt + 7'd1;
                                if (sample_now) begin
                                    rx_sh <= rx_next;
                                end
                                if (update_now) begin
                                    tx_sh <= tx_next;
                                    mosi  <= first_bit(tx_next, lsb_r);
                                end
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    WAIT: begin
                        if (start) begin
                            state    <= SHIFT;
                            cnt      <= '0;
                            edge_cnt <= '0;
                            tx_sh    <= tx_data;
                            last_r   <= last;
                            busy     <= 1'b1;
                            mosi     <= first_bit(tx_data, lsb_r);
                        end
                    end
                    HOLD: begin
                        if (cnt == 16'(CS_HOLD - 1)) begin
                            state <= IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                            cs_n  <= 1'b1;
                            sck   <= cpol;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cs_n  <= 1'b1;
                        mosi  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
